// File: rtl/census_match_if.sv
// Pixel-side bus for census_match: census signature pair in, matched disparity/cost out.
// The bench drives through master; the matcher connects through slave.
interface census_match_if #(
    parameter int SIG_WIDTH  = 24,
    parameter int DISP_WIDTH = 4,
    parameter int COST_WIDTH = 5
);
    logic                  in_valid;
    logic                  sol;
    logic [SIG_WIDTH-1:0]  left_sig;
    logic [SIG_WIDTH-1:0]  right_sig;
    logic                  out_valid;
    logic [DISP_WIDTH-1:0] disparity;
    logic [COST_WIDTH-1:0] cost;
    logic                  out_invalid;

    modport master (
        output in_valid, sol, left_sig, right_sig,
        input  out_valid, disparity, cost, out_invalid
    );

    modport slave (
        input  in_valid, sol, left_sig, right_sig,
        output out_valid, disparity, cost, out_invalid
    );
endinterface

// File: rtl/census_match.sv
// Census stereo matcher: Hamming cost over MAX_DISP right-signature history, min-select winner.
// Latency 2 enabled cycles; no back-pressure, en=0 freezes everything. Option macro: CENSUS_MATCH_THRESH_EN.
// Backpressure: none; every pixel with en=1 and in_valid=1 is accepted.
module census_match #(
    parameter int SIG_WIDTH  = 24,
    parameter int MAX_DISP   = 16,
    parameter int DISP_WIDTH = 4,
    parameter int COST_WIDTH = 5,
    parameter int THRESH     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    census_match_if.slave  bus
);
    localparam logic [DISP_WIDTH-1:0] LP_FILL_MAX = DISP_WIDTH'(MAX_DISP - 1);

    if ((MAX_DISP < 2) || ((2 ** DISP_WIDTH) < MAX_DISP) || ((2 ** COST_WIDTH) <= SIG_WIDTH)
        || (THRESH < 0) || (THRESH > SIG_WIDTH)) begin : g_bad_params
        $error("census_match: inconsistent parameters");
    end

    function automatic logic [COST_WIDTH-1:0] popcnt(input logic [SIG_WIDTH-1:0] v);
        logic [COST_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < SIG_WIDTH; i++) c = c + COST_WIDTH'(v[i]);
        return c;
    endfunction

    // r_hist[i] holds the right signature accepted i+1 pixels ago; the current one is entry 0.
    logic [SIG_WIDTH-1:0]  r_hist [MAX_DISP-1];
    logic [DISP_WIDTH-1:0] r_fill;
    logic [DISP_WIDTH-1:0] w_fill_seen;
    logic [SIG_WIDTH-1:0]  w_cand [MAX_DISP];
    logic [COST_WIDTH-1:0] w_cost [MAX_DISP];
    logic [MAX_DISP-1:0]   w_mask;
    logic                  w_accept;

    logic                  r_v1;
    logic [COST_WIDTH-1:0] r_cost [MAX_DISP];
    logic [MAX_DISP-1:0]   r_mask;

    logic                  r_v2;
    logic [DISP_WIDTH-1:0] r_disp;
    logic [COST_WIDTH-1:0] r_best;
    logic [COST_WIDTH-1:0] w_best_cost;
    logic [DISP_WIDTH-1:0] w_best_disp;

    assign w_accept    = en & bus.in_valid;
    assign w_fill_seen = bus.sol ? '0 : r_fill;
    assign w_cand[0]   = bus.right_sig;

    for (genvar d = 0; d < MAX_DISP; d++) begin : g_cand
        localparam logic [DISP_WIDTH-1:0] LP_D = DISP_WIDTH'(d);
        if (d > 0) begin : g_hist
            assign w_cand[d] = r_hist[d-1];
        end
        assign w_cost[d] = popcnt(bus.left_sig ^ w_cand[d]);
        assign w_mask[d] = (LP_D <= w_fill_seen);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill <= '0;
            r_v1   <= 1'b0;
            r_mask <= '0;
            for (int i = 0; i < MAX_DISP - 1; i++) r_hist[i] <= '0;
            for (int d = 0; d < MAX_DISP; d++) r_cost[d] <= '0;
        end else if (en) begin
            r_v1 <= bus.in_valid;
            if (w_accept) begin
                r_hist[0] <= bus.right_sig;
                for (int i = 1; i < MAX_DISP - 1; i++) r_hist[i] <= r_hist[i-1];
                if (bus.sol)                  r_fill <= DISP_WIDTH'(1);
                else if (r_fill != LP_FILL_MAX) r_fill <= r_fill + DISP_WIDTH'(1);
                for (int d = 0; d < MAX_DISP; d++) r_cost[d] <= w_cost[d];
                r_mask <= w_mask;
            end
        end
    end

    // Strict less-than keeps the lowest disparity on ties; entry 0 is always a candidate.
    always_comb begin
        w_best_cost = r_cost[0];
        w_best_disp = '0;
        for (int d = 1; d < MAX_DISP; d++) begin
            if (r_mask[d] && (r_cost[d] < w_best_cost)) begin
                w_best_cost = r_cost[d];
                w_best_disp = DISP_WIDTH'(d);
            end
        end
    end

`ifdef CENSUS_MATCH_THRESH_EN
    logic r_inv;
    logic w_reject;

    assign w_reject = (w_best_cost > COST_WIDTH'(THRESH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2   <= 1'b0;
            r_disp <= '0;
            r_best <= '0;
            r_inv  <= 1'b0;
        end else if (en) begin
            r_v2  <= r_v1;
            r_inv <= r_v1 & w_reject;
            if (r_v1) begin
                r_disp <= w_reject ? '0 : w_best_disp;
                r_best <= w_best_cost;
            end
        end
    end

    assign bus.out_invalid = r_inv;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2   <= 1'b0;
            r_disp <= '0;
            r_best <= '0;
        end else if (en) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_disp <= w_best_disp;
                r_best <= w_best_cost;
            end
        end
    end

    assign bus.out_invalid = 1'b0;
`endif

    assign bus.out_valid = r_v2;
    assign bus.disparity = r_disp;
    assign bus.cost      = r_best;
endmodule
